// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder: bit-serial WIDTH-bit adder built on a single 1-bit full_adder.
//
// Operands are latched on an accepted start and shifted LSB-first through the
// full_adder, one bit per clock. The cell's carry-out is registered and fed
// back as the next cycle's carry-in. Sum bits collect in a shift register and
// are copied to S/Cout only at the final bit, so S never shows a partial sum.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   start in   begin an addition (sampled only while idle)
//   A, B  in   WIDTH-bit operands, latched on the accepted start
//   Cin   in   initial carry-in, latched on the accepted start
//   busy  out  high while bits are being processed (WIDTH cycles)
//   done  out  one-cycle pulse; S/Cout valid from this cycle on
//   S     out  registered WIDTH-bit sum
//   Cout  out  registered final carry-out
//
// full_adder is the 1-bit cell from the combinational lab set, reproduced
// here so the block elaborates on its own.
// -----------------------------------------------------------------------------

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    // Only the upper WIDTH-1 sum bits need storage: the oldest bit of the
    // collected sum is shifted out on every step and never observed.
    logic [WIDTH-2:0] res_hi;
    logic [WIDTH-1:0] res_next;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .A    (sa[0]),
        .B    (sb[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Sum register after this step: new bit enters at the MSB.
    assign res_next = {fa_s, res_hi};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state == ADD);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            carry  <= 1'b0;
            res_hi <= '0;
            S      <= '0;
            Cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    sa     <= {1'b0, sa[WIDTH-1:1]};
                    sb     <= {1'b0, sb[WIDTH-1:1]};
                    carry  <= fa_cout;
                    res_hi <= res_next[WIDTH-1:1];
                    cnt    <= cnt + 1'b1;
                    // Outputs update only with the complete result.
                    if (last_bit) begin
                        S    <= res_next;
                        Cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder: directed and random checks of serial_adder (WIDTH=8) plus an
// exhaustive back-to-back sweep of a WIDTH=4 instance. Expected sums come from
// plain integer addition; expected timing from the documented latency.
// -----------------------------------------------------------------------------

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] s8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] s4;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One addition on the 8-bit instance. With poke set, start is re-asserted
    // and A altered mid-operation; neither may affect the result.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input bit poke);
        logic [8:0] exp;
        logic [7:0] s_prev;
        logic       cout_prev;
        int         nbusy, ndone, first_done;
        bit         held;
        exp = 9'(a) + 9'(b) + 9'(c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        s_prev = s8; cout_prev = cout8;
        nbusy = 0; ndone = 0; first_done = 0; held = 1'b1;
        // Sample k is taken after edge E0+k-1.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
            if (poke && k == 3) begin start8 = 1'b1; a8 = 8'h11; end
            if (poke && k == 6) start8 = 1'b0;
            if (busy8) nbusy++;
            if (done8) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (first_done == 0 && (s8 !== s_prev || cout8 !== cout_prev)) held = 1'b0;
        end
        check({tag, "_busy_cycles"}, nbusy, 8);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_done_latency"}, first_done, 9);
        check({tag, "_s_held"}, 32'(held), 1);
        check({tag, "_sum"}, 32'(s8), 32'(exp[7:0]));
        check({tag, "_cout"}, 32'(cout8), 32'(exp[8]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] exp4;
        int         waited, last_done, ndone;

        // Reset state.
        #1;
        check("rst_s8", 32'(s8), 0);
        check("rst_cout8", 32'(cout8), 0);
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_busy4", 32'(busy4), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run8("zero", 8'h00, 8'h00, 1'b0, 1'b0);
        run8("carry_chain", 8'hFF, 8'h01, 1'b0, 1'b0);
        run8("a5_5a_cin", 8'hA5, 8'h5A, 1'b1, 1'b0);
        run8("3c_42", 8'h3C, 8'h42, 1'b0, 1'b0);
        run8("3c_42_poke", 8'h3C, 8'h42, 1'b0, 1'b1);

        // Reset in the middle of FF+FF, at cnt=4.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
        end
        check("abort_busy_before", 32'(busy8), 1);
        rst = 1'b1;
        #1;
        check("abort_s", 32'(s8), 0);
        check("abort_cout", 32'(cout8), 0);
        check("abort_busy", 32'(busy8), 0);
        check("abort_done", 32'(done8), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        check("abort_no_activity", ndone, 0);
        run8("ff_ff_cin", 8'hFF, 8'hFF, 1'b1, 1'b0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            run8("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        // Exhaustive WIDTH=4 sweep with start held high.
        @(negedge clk);
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
        last_done = 0;
        for (int n = 0; n < 512; n++) begin
            exp4 = 5'(a4) + 5'(b4) + 5'(cin4);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!done4 && waited < 20);
            if (!done4) begin
                check("sweep_timeout", 32'(done4), 1);
                break;
            end
            check("sweep_sum", 32'({cout4, s4}), 32'(exp4));
            if (n > 0) check("sweep_spacing", cyc - last_done, 6);
            last_done = cyc;
            a4   = 4'((n + 1) >> 5);
            b4   = 4'((n + 1) >> 1);
            cin4 = 1'((n + 1) & 1);
        end
        start4 = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
